fifo_rd_stream_adapter: RTL and testbench



---
 rtl/fifo_rd_stream_adapter.sv | 83 ++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: show-ahead FIFO read port to valid/ready stream through a 2-entry skid buffer; FIFO_RD_CNT_EN adds rd_count
module fifo_rd_stream_adapter #(
    parameter int DATA_W = 8
`ifdef FIFO_RD_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rempty,
    input  logic [DATA_W-1:0] rdata,
    output logic              rinc,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    , output logic [CNT_W-1:0] rd_count
`endif
);

    typedef enum logic [1:0] {S0, S1, S2} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] slot0, slot1, slot0_n, slot1_n;
    logic              push, pop;

    // Pop decision uses only local occupancy, so rinc never waits on m_ready.
    assign push    = !rempty && (state != S2) && !flush && !rrst;
    assign rinc    = push;
    assign m_valid = (state != S0);
    assign m_data  = slot0;
    assign pop     = m_valid && m_ready;

    // State and skid slots; reset discards buffered words.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= S0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_n;
            slot0 <= slot0_n;
            slot1 <= slot1_n;
        end
    end

    // Next occupancy and slot contents; flush empties the buffer after any pop completes.
    always_comb begin
        state_n = state;
        slot0_n = slot0;
        slot1_n = slot1;
        case (state)
            S0: if (push) begin
                state_n = S1;
                slot0_n = rdata;
            end
            S1: if (push && !pop) begin
                state_n = S2;
                slot1_n = rdata;
            end else if (push && pop) begin
                slot0_n = rdata;
            end else if (pop) begin
                state_n = S0;
            end
            S2: if (pop) begin
                state_n = S1;
                slot0_n = slot1;
            end
            default: state_n = S0;
        endcase
        if (flush) state_n = S0;
    end

`ifdef FIFO_RD_CNT_EN
    // Delivered-word counter; wraps naturally, untouched by flush.
    always_ff @(posedge rclk) begin
        if (rrst) rd_count <= '0;
        else if (pop) rd_count <= rd_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb_fifo_rd_stream_adapter: scoreboard bench with a FIFO model feeding the adapter; FIFO_RD_CNT_EN enables rd_count checks
module tb_fifo_rd_stream_adapter;

    logic       rclk = 1'b0, rrst = 1'b1, rempty = 1'b1, flush = 1'b0, m_ready = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       rinc, m_valid;
    logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
    logic [3:0] rd_count;
`endif

    int vectors = 0, miscompares = 0, rinc_pulses = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    always #5 rclk = ~rclk;

`ifdef FIFO_RD_CNT_EN
    fifo_rd_stream_adapter #(.DATA_W(8), .CNT_W(4)) dut (
`else
    fifo_rd_stream_adapter #(.DATA_W(8)) dut (
`endif
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_RD_CNT_EN
        , .rd_count(rd_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'h00 : fifo_q[0];
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge rclk);
            drive();
        end
        #1;
    endtask

    task automatic load(input logic [7:0] w, input bit delivered);
        fifo_q.push_back(w);
        if (delivered) exp_q.push_back(w);
    endtask

    // FIFO model pop and stream monitor, sampled just before each rising edge
    always begin
        logic [7:0] e;
        @(negedge rclk);
        #4;
        if (rinc) begin
            rinc_pulses++;
            vectors++;
            if (rempty || fifo_q.size() == 0) begin
                miscompares++;
                $display("FAIL rinc_while_empty: rinc=1 rempty=%0b at %0t", rempty, $time);
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        if (m_valid && m_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", m_data, $time);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    miscompares++;
                    $display("FAIL stream_data: got %0h expected %0h at %0t", m_data, e, $time);
                end
            end
        end
    end

    initial begin
        int n;
        // reset held with a word available
        fifo_q.push_back(8'h99);
        repeat (3) begin
            step();
            check("rst_rinc", rinc, 0);
            check("rst_valid", m_valid, 0);
            check("rst_data", m_data, 0);
        end
        fifo_q.delete();
        rrst = 1'b0;
        drive();
        step();
        check("idle_valid", m_valid, 0);
        // three words streamed at full rate
        m_ready = 1'b1;
        load(8'h11, 1); load(8'h22, 1); load(8'h33, 1);
        step(); check("t2_rinc0", rinc, 1); check("t2_valid0", m_valid, 0);
        step(); check("t2_rinc1", rinc, 1); check("t2_data0", m_data, 8'h11);
        step(); check("t2_rinc2", rinc, 1); check("t2_data1", m_data, 8'h22);
        step(); check("t2_rinc3", rinc, 0); check("t2_data2", m_data, 8'h33); check("t2_valid3", m_valid, 1);
        step(); check("t2_valid_end", m_valid, 0);
        // backpressure fills the skid buffer, then drains with no gaps
        m_ready = 1'b0;
        rinc_pulses = 0;
        for (int i = 0; i < 4; i++) load(8'h41 + 8'(i), 1);
        step(5);
        check("t3_pulses", rinc_pulses, 2);
        check("t3_full_valid", m_valid, 1);
        check("t3_hold_data", m_data, 8'h41);
        check("t3_full_rinc", rinc, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t3_nogap", m_valid, 1);
            check("t3_order", m_data, 8'h41 + i);
            step();
        end
        check("t3_valid_end", m_valid, 0);
        // empty FIFO with toggling ready
        for (int i = 0; i < 8; i++) begin
            m_ready = ~m_ready;
            step();
            check("t4_rinc", rinc, 0);
            check("t4_valid", m_valid, 0);
        end
        // flush a full buffer, next FIFO word is the first delivered
        m_ready = 1'b0;
        load(8'hA5, 0); load(8'h5A, 0);
        step(3);
        load(8'h77, 1);
        step();
        check("t5_full_rinc", rinc, 0);
        check("t5_full_data", m_data, 8'hA5);
        flush = 1'b1;
        #1;
        check("t5_flush_rinc", rinc, 0);
        step();
        flush = 1'b0;
        #1;
        check("t5_flushed_valid", m_valid, 0);
        check("t5_refill_rinc", rinc, 1);
        m_ready = 1'b1;
        step();
        check("t5_first_valid", m_valid, 1);
        check("t5_first_data", m_data, 8'h77);
        step();
        check("t5_valid_end", m_valid, 0);
`ifdef FIFO_RD_CNT_EN
        // counter wraps after 16 deliveries and is cleared by reset
        rrst = 1'b1;
        step();
        check("t6_cnt_rst", rd_count, 0);
        rrst = 1'b0;
        for (int i = 0; i < 17; i++) load(8'(i + 1), 1);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin step(); n++; end
        step(2);
        check("t6_cnt_wrap", rd_count, 1);
        rrst = 1'b1;
        step();
        check("t6_cnt_clear", rd_count, 0);
        rrst = 1'b0;
`endif
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin step(); n++; end
        check("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
